inner_loop_mp: RTL and testbench

Parametrised multi-precision row multiplier for the Montgomery inner loop. It computes A·b_i for an (SIZE+2)-bit operand A and a RADIX-bit digit b_i. The operand is split into LIMBS = ceil((SIZE+2)/RADIX) limbs and processed in PASSES = ceil(LIMBS/BLOCKS) passes over BLOCKS parallel multiplier lanes. Results are returned in redundant form: r0 holds the low limb halves and r1 holds the high halves shifted one limb up, so A·b_i = r0 + r1. The block sits between operand fetch and the outer-loop accumulator, and replaces the fixed 3072/78/20-lane variant with valid/ready handshakes.

---
 rtl/inner_loop_mp.sv | 163 ++++++++++++++++
 tb/tb_inner_loop_mp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inner_loop_mp.sv
// inner_loop_mp: multi-precision row multiplier computing A*b_i for the Montgomery inner loop.
// A is split into RADIX-bit limbs and streamed over BLOCKS parallel lanes in PASSES passes.
// The result is redundant: r0 holds the low product halves, r1 the high halves one limb up,
// so A*b_i = r0 + r1. Latency: a handshake in cycle c0 gives out_valid in cycle
// c0 + PASSES + MUL_LAT + 1 (one more with the sum adder).
// Optional feature: define INNER_LOOP_MP_SUM_EN to add a registered sum = r0 + r1 port.
module inner_loop_mp #(
    parameter int unsigned SIZE    = 3072,
    parameter int unsigned RADIX   = 78,
    parameter int unsigned BLOCKS  = 20,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE+1:0]       a,
    input  logic [RADIX-1:0]      bi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE+RADIX+1:0] r0,
    output logic [SIZE+RADIX+1:0] r1
`ifdef INNER_LOOP_MP_SUM_EN
    ,
    output logic [SIZE+RADIX+1:0] sum
`endif
);

    localparam int unsigned W        = SIZE + RADIX + 2;
    localparam int unsigned LIMBS    = (SIZE + 2 + RADIX - 1) / RADIX;
    localparam int unsigned PASSES   = (LIMBS + BLOCKS - 1) / BLOCKS;
    localparam int unsigned PCW      = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned PRW      = 2 * RADIX;
    localparam int unsigned APW      = PASSES * BLOCKS * RADIX;
    localparam int unsigned TOP      = LIMBS - 1;
    localparam int unsigned TOP_LANE = TOP % BLOCKS;
    localparam int unsigned TOP_PASS = TOP / BLOCKS;
    // Bits of the top high half that land below W; the rest are provably zero.
    localparam int unsigned TOP_HI   = SIZE + 2 - TOP * RADIX;
    localparam logic [PCW-1:0] LAST_P = PCW'(PASSES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

    state_e                 state_q;
    logic [PCW-1:0]         p_q;
    logic [SIZE+1:0]        a_q;
    logic [RADIX-1:0]       bi_q;
    logic [LIMBS*RADIX-1:0] r0_q;
    // r1 without its always-zero low limb.
    logic [SIZE+1:0]        r1_q;
    logic [MUL_LAT-1:0]     vld_q;
    logic [PCW-1:0]         tag_q  [MUL_LAT];
    logic [PRW-1:0]         prod_q [MUL_LAT][BLOCKS];
    logic [APW-1:0]         a_pad;
    logic [PRW-1:0]         mul    [BLOCKS];
    logic                   drain_done;

    // Lane operands for the current pass; limbs past the top are zero via padding.
    always_comb begin
        a_pad = APW'(a_q);
        for (int j = 0; j < int'(BLOCKS); j++) begin
            mul[j] = PRW'(a_pad[(int'(p_q) * int'(BLOCKS) + j) * int'(RADIX) +: RADIX])
                   * PRW'(bi_q);
        end
    end

    // Drain ends when the only product left is the one written back this cycle
    // (or none at all when the sum adder needs a settled r0/r1).
    always_comb begin
        drain_done = 1'b1;
        for (int s = 0; s + 1 < int'(MUL_LAT); s++) begin
            if (vld_q[s]) drain_done = 1'b0;
        end
`ifdef INNER_LOOP_MP_SUM_EN
        if (vld_q[MUL_LAT-1]) drain_done = 1'b0;
`endif
    end

    // Lane multiplier pipelines with their pass tags; validity is tracked separately.
    always_ff @(posedge clk) begin
        tag_q[0] <= p_q;
        for (int j = 0; j < int'(BLOCKS); j++) prod_q[0][j] <= mul[j];
        for (int s = 1; s < int'(MUL_LAT); s++) begin
            tag_q[s] <= tag_q[s-1];
            for (int j = 0; j < int'(BLOCKS); j++) prod_q[s][j] <= prod_q[s-1][j];
        end
    end

    // Control FSM, valid chain and result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            vld_q   <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
        end else begin
            vld_q[0] <= (state_q == StIssue);
            for (int s = 1; s < int'(MUL_LAT); s++) vld_q[s] <= vld_q[s-1];

            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        bi_q    <= bi;
                        r0_q    <= '0;
                        r1_q    <= '0;
                        p_q     <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (p_q == LAST_P) state_q <= StDrain;
                    else               p_q     <= p_q + 1'b1;
                end
                StDrain: begin
                    if (drain_done) state_q <= StHold;
                end
                StHold: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Limb k comes from lane k % BLOCKS in pass k / BLOCKS.
            if (vld_q[MUL_LAT-1]) begin
                for (int k = 0; k < int'(LIMBS); k++) begin
                    if (tag_q[MUL_LAT-1] == PCW'(k / int'(BLOCKS))) begin
                        r0_q[k*int'(RADIX) +: RADIX] <=
                            prod_q[MUL_LAT-1][k % int'(BLOCKS)][RADIX-1:0];
                    end
                end
                for (int k = 0; k < int'(TOP); k++) begin
                    if (tag_q[MUL_LAT-1] == PCW'(k / int'(BLOCKS))) begin
                        r1_q[k*int'(RADIX) +: RADIX] <=
                            prod_q[MUL_LAT-1][k % int'(BLOCKS)][PRW-1:RADIX];
                    end
                end
                if (tag_q[MUL_LAT-1] == PCW'(TOP_PASS)) begin
                    r1_q[SIZE+1:TOP*RADIX] <= prod_q[MUL_LAT-1][TOP_LANE][RADIX +: TOP_HI];
                end
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StHold);
    assign r0        = W'(r0_q);
    assign r1        = {r1_q, {RADIX{1'b0}}};

`ifdef INNER_LOOP_MP_SUM_EN
    logic [W-1:0] sum_q;

    // Collapse the redundant form; settles one cycle after the last write-back.
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= r0 + r1;
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_inner_loop_mp.sv
// Bench for inner_loop_mp: default-parameter instance plus a small (254/17/4/1) instance,
// checked against a limb-level arithmetic model and the plain product a*bi.
`timescale 1ns/1ps
module tb_inner_loop_mp;

    localparam int SIZE1 = 3072, RADIX1 = 78, W1 = SIZE1 + RADIX1 + 2;
    localparam int SIZE2 = 254,  RADIX2 = 17, W2 = SIZE2 + RADIX2 + 2;
`ifdef INNER_LOOP_MP_SUM_EN
    localparam int SUM_LAT = 1;
`else
    localparam int SUM_LAT = 0;
`endif
    // Cycles from the handshake cycle to the first out_valid cycle: PASSES + MUL_LAT + 1.
    localparam int LAT1 = 2 + 2 + 1 + SUM_LAT;
    localparam int LAT2 = 4 + 1 + 1 + SUM_LAT;

    typedef logic [W1-1:0] big_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              in_valid1, in_ready1, out_valid1, out_ready1;
    logic [SIZE1+1:0]  a1;
    logic [RADIX1-1:0] bi1;
    logic [W1-1:0]     r0_1, r1_1;
    logic              in_valid2, in_ready2, out_valid2, out_ready2;
    logic [SIZE2+1:0]  a2;
    logic [RADIX2-1:0] bi2;
    logic [W2-1:0]     r0_2, r1_2;
`ifdef INNER_LOOP_MP_SUM_EN
    logic [W1-1:0]     sum_1;
    logic [W2-1:0]     sum_2;
`endif

    inner_loop_mp dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .bi(bi1),
        .out_valid(out_valid1), .out_ready(out_ready1), .r0(r0_1), .r1(r1_1)
`ifdef INNER_LOOP_MP_SUM_EN
        , .sum(sum_1)
`endif
    );

    inner_loop_mp #(.SIZE(SIZE2), .RADIX(RADIX2), .BLOCKS(4), .MUL_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .bi(bi2),
        .out_valid(out_valid2), .out_ready(out_ready2), .r0(r0_2), .r1(r1_2)
`ifdef INNER_LOOP_MP_SUM_EN
        , .sum(sum_2)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    big_t ta, tb, x0, x1, g0, g1, gs, ones78;
    big_t ba [8], bb [8], e0 [8], e1 [8];
    int   lat, cyc, last, nres, nacc, seen;
    logic acc, res;

    task automatic check(input string tag, input big_t got, input big_t exp);
        int d;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            d = -1;
            for (int i = 0; i < W1; i++) begin
                if (d < 0 && got[i] !== exp[i]) d = i;
            end
            $display("FAIL %s: got[127:0]=%h exp[127:0]=%h first differing bit %0d",
                     tag, got[127:0], exp[127:0], d);
        end
    endtask

    // Spec-level redundant result: per-limb products split into low/high halves.
    function automatic void model(input int size, input int radix, input big_t a,
                                  input big_t b, output big_t r0, output big_t r1);
        int   limbs;
        big_t mask, limb, pr;
        limbs = (size + 2 + radix - 1) / radix;
        mask  = (big_t'(1) << radix) - big_t'(1);
        r0 = '0;
        r1 = '0;
        for (int k = 0; k < limbs; k++) begin
            limb = (a >> (k * radix)) & mask;
            pr   = limb * b;
            r0   = r0 | ((pr & mask) << (k * radix));
            r1   = r1 | ((pr >> radix) << ((k + 1) * radix));
        end
        r1 = r1 & ((big_t'(1) << (size + radix + 2)) - big_t'(1));
    endfunction

    function automatic big_t rand_big(input int bits);
        big_t r = '0;
        for (int i = 0; i < (bits + 31) / 32; i++) r = (r << 32) | big_t'($urandom);
        return r & ((big_t'(1) << bits) - big_t'(1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input big_t a, input big_t b, output big_t o0, output big_t o1,
                       output big_t os, output int l);
        int w = 0;
        while (!in_ready1 && w < 20) begin tick(); w++; end
        a1 = a[SIZE1+1:0];
        bi1 = b[RADIX1-1:0];
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        l = 1;
        while (!out_valid1 && l < 60) begin tick(); l++; end
        o0 = r0_1;
        o1 = r1_1;
`ifdef INNER_LOOP_MP_SUM_EN
        os = sum_1;
`else
        os = '0;
`endif
    endtask

    task automatic op2(input big_t a, input big_t b, output big_t o0, output big_t o1,
                       output big_t os, output int l);
        int w = 0;
        while (!in_ready2 && w < 20) begin tick(); w++; end
        a2 = a[SIZE2+1:0];
        bi2 = b[RADIX2-1:0];
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        l = 1;
        while (!out_valid2 && l < 60) begin tick(); l++; end
        o0 = big_t'(r0_2);
        o1 = big_t'(r1_2);
`ifdef INNER_LOOP_MP_SUM_EN
        os = big_t'(sum_2);
`else
        os = '0;
`endif
    endtask

    task automatic release1();
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; bi1 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; bi2 = '0;
        ones78 = (big_t'(1) << 78) - big_t'(1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", big_t'(in_ready1), 1);
        check("rst_out_valid", big_t'(out_valid1), 0);
        check("rst_r0", r0_1, '0);
        check("rst_r1", r1_1, '0);
        check("rst_in_ready2", big_t'(in_ready2), 1);
        rst = 1'b0;
        tick();

        // a = 1, bi = 2^78-1
        op1(1, ones78, g0, g1, gs, lat);
        check("one_lat", lat, LAT1);
        check("one_r0", g0, ones78);
        check("one_r1", g1, '0);
`ifdef INNER_LOOP_MP_SUM_EN
        check("one_sum", gs, ones78);
`endif
        release1();

        // a = 2^3074-1, bi = 2^78-1
        ta = (big_t'(1) << (SIZE1 + 2)) - big_t'(1);
        model(SIZE1, RADIX1, ta, ones78, x0, x1);
        op1(ta, ones78, g0, g1, gs, lat);
        check("max_lat", lat, LAT1);
        check("max_r0", g0, x0);
        check("max_r1", g1, x1);
        check("max_total", g0 + g1, ta * ones78);
        check("max_r1_low", g1 & ones78, '0);
        check("max_r1_top", g1 >> 3120, x1 >> 3120);
`ifdef INNER_LOOP_MP_SUM_EN
        check("max_sum", gs, ta * ones78);
`endif
        release1();

        // Back-pressure with ignored in_valid pulses in HOLD
        ta = rand_big(SIZE1 + 2);
        tb = rand_big(RADIX1);
        model(SIZE1, RADIX1, ta, tb, x0, x1);
        op1(ta, tb, g0, g1, gs, lat);
        check("bp_lat", lat, LAT1);
        for (int i = 0; i < 10; i++) begin
            in_valid1 = (i % 3 == 0);
            a1 = rand_big(SIZE1 + 2);
            tick();
            check("bp_out_valid", big_t'(out_valid1), 1);
            check("bp_in_ready", big_t'(in_ready1), 0);
            check("bp_r0", r0_1, x0);
            check("bp_r1", r1_1, x1);
        end
        in_valid1 = 1'b0;
        release1();
        check("bp_rel_in_ready", big_t'(in_ready1), 1);
        check("bp_rel_out_valid", big_t'(out_valid1), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid1) seen++;
        end
        check("bp_no_queue", seen, 0);

        // Reset in the middle of ISSUE
        a1 = rand_big(SIZE1 + 2);
        bi1 = rand_big(RADIX1);
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", big_t'(in_ready1), 1);
        check("mid_rst_out_valid", big_t'(out_valid1), 0);
        check("mid_rst_r0", r0_1, '0);
        check("mid_rst_r1", r1_1, '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid1 || r0_1 != '0 || r1_1 != '0) seen++;
        end
        check("mid_rst_quiet", seen, 0);

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 8; i++) begin
            ba[i] = rand_big(SIZE1 + 2);
            bb[i] = rand_big(RADIX1);
            model(SIZE1, RADIX1, ba[i], bb[i], e0[i], e1[i]);
        end
        out_ready1 = 1'b1;
        a1 = ba[0][SIZE1+1:0];
        bi1 = bb[0][RADIX1-1:0];
        in_valid1 = 1'b1;
        cyc = 0; last = 0; nres = 0; nacc = 0;
        while (nres < 8 && cyc < 300) begin
            acc = in_valid1 && in_ready1;
            res = out_valid1 && out_ready1;
            if (res) begin
                check("b2b_r0", r0_1, e0[nres]);
                check("b2b_r1", r1_1, e1[nres]);
                if (nres > 0) check("b2b_interval", cyc - last, LAT1 + 1);
                last = cyc;
                nres++;
            end
            tick();
            cyc++;
            if (acc) begin
                nacc++;
                if (nacc < 8) begin
                    a1 = ba[nacc][SIZE1+1:0];
                    bi1 = bb[nacc][RADIX1-1:0];
                end else begin
                    in_valid1 = 1'b0;
                end
            end
        end
        check("b2b_count", nres, 8);
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        tick();

        // Parameter sweep on the small instance
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                ta = (big_t'(1) << (SIZE2 + 2)) - big_t'(1);
                tb = (big_t'(1) << RADIX2) - big_t'(1);
            end else begin
                ta = rand_big(SIZE2 + 2);
                tb = rand_big(RADIX2);
            end
            model(SIZE2, RADIX2, ta, tb, x0, x1);
            op2(ta, tb, g0, g1, gs, lat);
            out_ready2 = 1'b1;
            tick();
            out_ready2 = 1'b0;
            check("sw_lat", lat, LAT2);
            check("sw_total", g0 + g1, ta * tb);
            check("sw_r0", g0, x0);
            check("sw_r1", g1, x1);
`ifdef INNER_LOOP_MP_SUM_EN
            check("sw_sum", gs, ta * tb);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
